// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit add-with-carry datapath among NUM_REQ requesters.
// Optional signed-overflow output res_ovf_o is enabled by defining ADDER_SHARE_ARBITER_OVF_EN.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_a_i,
    input  logic [8*NUM_REQ-1:0]   req_b_i,
    input  logic [NUM_REQ-1:0]     req_cin_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [7:0]             res_sum_o,
    output logic                   res_cout_o,
    output logic [ID_W-1:0]        res_id_o
`ifdef ADDER_SHARE_ARBITER_OVF_EN
    ,
    output logic                   res_ovf_o
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q;
    logic              res_valid_q;
    logic [7:0]        res_sum_q;
    logic              res_cout_q;
    logic [ID_W-1:0]   res_id_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic              res_ovf_q;

    logic              found_s;
    logic [ID_W-1:0]   win_idx_s;
    int                idx_v;
    logic              free_s;
    logic              accept_s;
    logic [7:0]        a_s;
    logic [7:0]        b_s;
    logic              cin_s;
    logic [8:0]        sum_d;
    logic              ovf_d;

    // Round-robin search: first valid requester after the last winner, wrapping.
    always_comb begin
        found_s   = 1'b0;
        win_idx_s = '0;
        idx_v     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_v = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found_s && req_valid_i[idx_v]) begin
                found_s   = 1'b1;
                win_idx_s = ID_W'(idx_v);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Output register is free when empty, or when its current result drains this edge.
    always_comb begin
        if (state_q == ST_EMPTY) begin
            free_s = 1'b1;
        end else begin
            free_s = res_ready_i;
        end
        accept_s = free_s && found_s && !rst_i;
        if (accept_s) begin
            req_ready_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
        end else begin
            req_ready_o = '0;
        end
    end

    // Shared adder operating on the winner's operands.
    always_comb begin
        a_s   = req_a_i[8*win_idx_s +: 8];
        b_s   = req_b_i[8*win_idx_s +: 8];
        cin_s = req_cin_i[win_idx_s];
        sum_d = {1'b0, a_s} + {1'b0, b_s} + {8'b0000_0000, cin_s};
        ovf_d = (a_s[7] == b_s[7]) && (sum_d[7] != a_s[7]);
    end

    // Result FSM with registered outputs and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            res_valid_q <= 1'b0;
            res_sum_q   <= 8'h00;
            res_cout_q  <= 1'b0;
            res_id_q    <= '0;
            res_ovf_q   <= 1'b0;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_q     <= ST_FULL;
                        res_valid_q <= 1'b1;
                        res_sum_q   <= sum_d[7:0];
                        res_cout_q  <= sum_d[8];
                        res_id_q    <= win_idx_s;
                        res_ovf_q   <= ovf_d;
                        rr_ptr_q    <= win_idx_s;
                    end else begin
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept_s) begin
                        // Drain and reload on the same edge: back-to-back results.
                        res_valid_q <= 1'b1;
                        res_sum_q   <= sum_d[7:0];
                        res_cout_q  <= sum_d[8];
                        res_id_q    <= win_idx_s;
                        res_ovf_q   <= ovf_d;
                        rr_ptr_q    <= win_idx_s;
                    end else if (res_ready_i) begin
                        state_q     <= ST_EMPTY;
                        res_valid_q <= 1'b0;
                    end else begin
                        state_q     <= ST_FULL;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_sum_o   = res_sum_q;
    assign res_cout_o  = res_cout_q;
    assign res_id_o    = res_id_q;
`ifdef ADDER_SHARE_ARBITER_OVF_EN
    assign res_ovf_o   = res_ovf_q;
`endif

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 8-bit add-with-carry-in datapath (sum = a + b + cin) among NUM_REQ requesters.
- Arbitration is round-robin.
- Each request is one operand set {a, b, cin}. The block computes the 9-bit result and holds it in an output register, tagged with the requester ID, until a downstream consumer accepts it.
- Sits between multiple client blocks and the single adder instance, so the adder is never duplicated.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of res_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request; bit i belongs to requester i.
- req_a  input  8*NUM_REQ  operand A; bits [8i+7:8i] belong to requester i.
- req_b  input  8*NUM_REQ  operand B, packed the same way as req_a.
- req_cin  input  NUM_REQ  carry-in; bit i belongs to requester i.
- req_ready  output  NUM_REQ  one-hot accept strobe; bit i high means requester i's operands are taken this cycle.
- res_valid  output  1  result register holds a valid result.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  8  low 8 bits of a + b + cin.
- res_cout  output  1  bit 8 of a + b + cin.
- res_id  output  ID_W  index of the requester that produced the result.

Behaviour:
- Reset (async, rst=1): res_valid=0, res_sum=0, res_cout=0, res_id=0, rr_ptr=NUM_REQ-1, state=EMPTY.
  - req_ready is combinational and is 0 while rst=1.
- Arithmetic: {res_cout, res_sum} = zero-extend-to-9-bits(a) + zero-extend(b) + cin.
  - Examples: 0xFF+0x00+1 = {1, 0x00}; 0xFF+0xFF+1 = {1, 0xFF}.
- State machine (2 states), with the output register free when state=EMPTY, or when state=FULL and res_ready=1:
  - EMPTY: res_valid=0. If any req_valid, accept the winner and go to FULL next cycle; otherwise stay in EMPTY.
  - FULL: res_valid=1. Result outputs are stable while res_ready=0.
    - res_ready=1 and a new winner exists: load the new result and stay FULL. This is back-to-back operation, one result per cycle.
    - res_ready=1 and no request: go to EMPTY.
- Latency: operands accepted in cycle N (req_ready[i]=1) appear on res_* with res_valid=1 in cycle N+1.
- Arbitration:
  - Winner is the first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ..., wrapping modulo NUM_REQ.
  - req_ready[winner]=1 only when the output register is free; at most one bit is high.
  - rr_ptr updates to the winner only on accept. No pointer movement when the block is stalled or idle.
- Requester rule: hold req_valid and operands stable until req_ready. The block samples operands only in the accept cycle.
  - Deasserting req_valid before accept withdraws the request legally.
- Wrap-around:
  - A requester at index NUM_REQ-1 followed by index 0 is a normal rotation.
  - With all requesters active continuously, grants cycle 0,1,2,3,0,...
- Simultaneous drain and load in FULL with res_ready=1: the old result is consumed and the new one is loaded in the same edge. No bubble, no loss.
- Mid-operation reset: all state clears immediately.
  - A pending result is discarded and req_ready drops.
  - After release, the first grant goes to the lowest-index active requester (rr_ptr=NUM_REQ-1).

Optional Feature:
- Macro: ADDER_SHARE_ARBITER_OVF_EN.
- Defined:
  - Adds output port res_ovf (1 bit): signed two's-complement overflow of a + b + cin, i.e. a[7]==b[7] and res_sum[7]!=a[7].
  - res_ovf is registered with the other res_* outputs and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: assert rst mid-run with FULL state -> res_valid=0, res_sum=0, res_id=0, req_ready=0 immediately. After release with req_valid=4'b1010, first grant goes to requester 1.
- Single op: req_valid=4'b0001, a=0x4A, b=0x53, cin=0 -> next cycle res_valid=1, res_sum=0x9D, res_cout=0, res_id=0. With OVF_EN, res_ovf=1.
- Carry boundary: requester 2, a=0xFF, b=0x00, cin=1 -> res_sum=0x00, res_cout=1, res_id=2.
- Round-robin fairness: req_valid=4'b1111 held, res_ready=1 -> res_id sequence 0,1,2,3,0,1, one result per cycle, no gaps.
- Backpressure: res_ready=0 for 5 cycles while FULL -> res_* stable, req_ready=0, rr_ptr unchanged. Raising res_ready gives the next grant in the same cycle.
- Withdrawal: requester 3 raises req_valid for 1 cycle while stalled, then drops it -> requester 3 is never granted and no result with res_id=3 appears.
